// File: rtl/spi_rx_deser.sv
// Oversampling SPI slave deserializer: WORD_W-bit frames out on a valid/ready handshake.
// Define SPI_RX_LSB_FIRST_EN to shift LSB-first; the default build is MSB-first.
`timescale 1ns/1ps
module spi_rx_deser #(
   parameter int WORD_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_l,
   input  logic              spi_sclk,
   input  logic              spi_data,
   input  logic              rx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              overrun,
   output logic [4:0]        bit_cnt
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   cs_dly_q, cs_dly_d, sclk_dly_q, sclk_dly_d;
   logic                   cs_s, sclk_s, data_s;
   logic                   cs_fall_s, cs_rise_s, sclk_rise_s;
   state_t                 state_q, state_d;
   logic [WORD_W-1:0]      shreg_q, shreg_d, rx_data_q, rx_data_d;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic                   extra_q, extra_d, deliver_q, deliver_d, err_pend_q, err_pend_d;
   logic                   rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;

   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_l};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], spi_data};
      cs_s        = cs_sync_q[SYNC_STAGES-1];
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      data_s      = data_sync_q[SYNC_STAGES-1];
      cs_dly_d    = cs_s;
      sclk_dly_d  = sclk_s;
      cs_fall_s   = cs_dly_q & ~cs_s;
      cs_rise_s   = ~cs_dly_q & cs_s;
      sclk_rise_s = ~sclk_dly_q & sclk_s;
   end

   // Frame FSM: cs edges are checked before sclk so chip-select always wins a tie.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      extra_d    = extra_q;
      deliver_d  = 1'b0;
      err_pend_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bit_cnt_d = 5'd0;
            extra_d   = 1'b0;
            if (cs_fall_s) begin
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cs_rise_s) begin
               state_d    = ST_IDLE;
               bit_cnt_d  = 5'd0;
               err_pend_d = (bit_cnt_q != 5'd0);
            end else if (sclk_rise_s) begin
`ifdef SPI_RX_LSB_FIRST_EN
               shreg_d = {data_s, shreg_q[WORD_W-1:1]};
`else
               shreg_d = {shreg_q[WORD_W-2:0], data_s};
`endif
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  deliver_d = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (cs_rise_s) begin
               state_d    = ST_IDLE;
               bit_cnt_d  = 5'd0;
               err_pend_d = extra_q;
               extra_d    = 1'b0;
            end else if (sclk_rise_s) begin
               extra_d = 1'b1;
            end else begin
               extra_d = extra_q;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            extra_d   = 1'b0;
         end
      endcase
   end

   // Output stage: a finished word lands one cycle after the last shift, so shreg is already frozen in DONE.
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      frame_err_d = err_pend_q;
      if (deliver_q) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
   end

   // State registers; the cs synchronizer resets to the deselected level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         sclk_sync_q <= {SYNC_STAGES{1'b0}};
         data_sync_q <= {SYNC_STAGES{1'b0}};
         cs_dly_q    <= 1'b1;
         sclk_dly_q  <= 1'b0;
         state_q     <= ST_IDLE;
         shreg_q     <= {WORD_W{1'b0}};
         bit_cnt_q   <= 5'd0;
         extra_q     <= 1'b0;
         deliver_q   <= 1'b0;
         err_pend_q  <= 1'b0;
         rx_data_q   <= {WORD_W{1'b0}};
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         data_sync_q <= data_sync_d;
         cs_dly_q    <= cs_dly_d;
         sclk_dly_q  <= sclk_dly_d;
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         extra_q     <= extra_d;
         deliver_q   <= deliver_d;
         err_pend_q  <= err_pend_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign bit_cnt   = bit_cnt_q;
endmodule
